// File: rtl/thermo_spi_reader.sv
// thermo_spi_reader: iomem-mapped reader for a 16-bit SPI thermocouple
// converter (MAX6675-style). Runs frames periodically or on demand,
// latches temperature / open-input flag, counts samples, pulses irq.
module thermo_spi_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [23:0] MIN_PERIOD = 24'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        cs_n,
  output logic        sck,
  input  logic        so,
  output logic        irq
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t      state, state_next;

  logic [1:0]  so_sync;
  logic        en;
  logic [23:0] period;
  logic [23:0] per_cnt;
  logic [11:0] temp;
  logic        open_flag;
  logic        data_valid;
  logic [15:0] sample_cnt;
  logic [15:0] raw;
  logic [15:0] shreg;
  logic [7:0]  div_cnt, div_next;
  logic [3:0]  bit_cnt, bit_next;
  logic        cs_n_next, sck_next;
  logic        shift_en, frame_done, per_reload;

  logic        sel, accept, wr, rd;
  logic [1:0]  reg_idx;
  logic        start_req, data_read, trigger;
  logic [31:0] period_merged;
  logic [23:0] period_wr;
  logic [31:0] read_mux;
  logic [15:0] frame;

  logic        unused_bits;
  assign unused_bits = ^{iomem_addr[1:0], period_merged[31:24]};

  // Bus decode: a request is taken only while ready is low, so every ack
  // is a single-cycle pulse and back-to-back acks cannot occur.
  assign sel       = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign accept    = sel && !iomem_ready;
  assign wr        = accept && (iomem_wstrb != 4'h0);
  assign rd        = accept && (iomem_wstrb == 4'h0);
  assign reg_idx   = iomem_addr[3:2];
  assign start_req = wr && (reg_idx == 2'd0) && iomem_wstrb[0] && iomem_wdata[1];
  assign data_read = rd && (reg_idx == 2'd2);
  assign trigger   = start_req || (en && (per_cnt == '0));
  assign frame     = {shreg[14:0], so_sync[1]};

  // PERIOD write value: byte-merge with the current value, then clamp.
  always_comb begin
    period_merged = {8'h00, period};
    for (int unsigned i = 0; i < 4; i++) begin
      if (iomem_wstrb[i]) period_merged[8*i +: 8] = iomem_wdata[8*i +: 8];
    end
    period_wr = (period_merged[23:0] < MIN_PERIOD) ? MIN_PERIOD : period_merged[23:0];
  end

  // Register read multiplexer.
  always_comb begin
    read_mux = '0;
    case (reg_idx)
      2'd0:    read_mux = {31'b0, en};
      2'd1:    read_mux = {8'h00, period};
      2'd2:    read_mux = {sample_cnt, 2'b00, data_valid, open_flag, temp};
      default: read_mux = {16'h0000, raw};
    endcase
  end

  // Bus acknowledge and read data (rdata is zero outside the ack cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= rd ? read_mux : '0;
    end
  end

  // Control registers: EN and PERIOD.
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      period <= MIN_PERIOD;
    end else if (wr) begin
      if (reg_idx == 2'd0 && iomem_wstrb[0]) en <= iomem_wdata[0];
      if (reg_idx == 2'd1) period <= period_wr;
    end
  end

  // Two-flop synchronizer for the asynchronous sensor data line.
  always_ff @(posedge clk) begin
    if (reset) so_sync <= '0;
    else       so_sync <= {so_sync[0], so};
  end

  // Period counter: reloads on every frame start, counts only while EN=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (per_reload) begin
      per_cnt <= period - 24'd1;
    end else if (en && (per_cnt != '0)) begin
      per_cnt <= per_cnt - 24'd1;
    end
  end

  // Frame FSM next-state and line control.
  always_comb begin
    state_next = state;
    cs_n_next  = cs_n;
    sck_next   = sck;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    per_reload = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = SETUP;
          cs_n_next  = 1'b0;
          sck_next   = 1'b0;
          div_next   = '0;
          bit_next   = '0;
          per_reload = 1'b1;
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_next = SHIFT;
          div_next   = '0;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if (!sck) begin
            sck_next = 1'b1;
          end else begin
            // Sample on the edge where sck falls; the 16th fall ends the frame.
            sck_next = 1'b0;
            shift_en = 1'b1;
            if (bit_cnt == 4'd15) begin
              state_next = HOLD;
              cs_n_next  = 1'b1;
              frame_done = 1'b1;
            end else begin
              bit_next = bit_cnt + 4'd1;
            end
          end
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (div_cnt == DIV_LAST) begin
          state_next = IDLE;
          div_next   = '0;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame FSM state, counters, sensor lines and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cs_n    <= cs_n_next;
      sck     <= sck_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      if (shift_en) shreg <= frame;
    end
  end

  // Result registers: a completing frame takes priority over a DATA read
  // clearing VALID in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw        <= '0;
      temp       <= '0;
      open_flag  <= 1'b0;
      data_valid <= 1'b0;
      sample_cnt <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= frame_done;
      if (frame_done) begin
        raw        <= frame;
        temp       <= frame[14:3];
        open_flag  <= frame[2];
        data_valid <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
      end else if (data_read) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thermo_spi_reader.sv
// Testbench for thermo_spi_reader: bus scoreboard, sensor model and
// spec-level register model.
module tb_thermo_spi_reader;

  localparam int          C    = 4;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        cs_n;
  logic        sck;
  logic        so;
  logic        irq;

  always #5 clk = ~clk;

  thermo_spi_reader #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (C),
    .MIN_PERIOD(24'd1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .cs_n       (cs_n),
    .sck        (sck),
    .so         (so),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } txn_t;
  txn_t sbq[$];

  logic ready_q = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (iomem_ready === 1'b1) begin
      check("ready_single_pulse", {31'b0, ready_q}, 32'h0);
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: ack with no request outstanding, addr %h", iomem_addr);
      end else begin
        t = sbq.pop_front();
        if (t.is_read) check(t.name, iomem_rdata, t.exp);
      end
    end
    ready_q = (iomem_ready === 1'b1);
  end

  // ---------------- irq monitor ----------------
  int   irq_count = 0;
  logic irq_q     = 1'b0;
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_count++;
      check("irq_one_cycle", {31'b0, irq_q}, 32'h0);
    end
    irq_q = (irq === 1'b1);
  end

  // ---------------- sensor model ----------------
  logic [15:0] sensor_word = 16'h0000;
  int          bit_idx     = 0;
  always @(negedge cs_n) begin
    bit_idx = 15;
    #1 so = sensor_word[15];
  end
  always @(negedge sck) begin
    if (cs_n === 1'b0) begin
      bit_idx--;
      if (bit_idx >= 0) #1 so = sensor_word[bit_idx];
    end
  end

  // ---------------- line timing tracker ----------------
  int   cyc = 0;
  int   low_cnt = 0, rise_cnt = 0, last_low = 0, last_rises = 0;
  logic cs_q = 1'b1, sck_q = 1'b0;
  int   fall_cyc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      if (cs_q) begin
        low_cnt  = 0;
        rise_cnt = 0;
        fall_cyc.push_back(cyc);
      end
      low_cnt++;
      if (sck === 1'b1 && !sck_q) rise_cnt++;
    end else if (!cs_q) begin
      last_low   = low_cnt;
      last_rises = rise_cnt;
    end
    cs_q  = (cs_n !== 1'b0);
    sck_q = (sck === 1'b1);
  end

  // ---------------- reference model ----------------
  logic        m_en;
  logic [23:0] m_period;
  logic [15:0] m_cnt;
  logic [15:0] m_raw;
  logic        m_valid;
  int          frame_exp;

  function logic [31:0] m_data();
    return {m_cnt, 2'b00, m_valid, m_raw[2], m_raw[14:3]};
  endfunction

  function void m_frame(input logic [15:0] w);
    m_raw   = w;
    m_valid = 1'b1;
    m_cnt   = m_cnt + 16'd1;
  endfunction

  function void m_reset();
    m_en     = 1'b0;
    m_period = 24'd1024;
    m_cnt    = '0;
    m_raw    = '0;
    m_valid  = 1'b0;
  endfunction

  // ---------------- bus driver ----------------
  task automatic bus(input logic [1:0] idx, input logic [3:0] strb, input logic [31:0] wd,
                     input logic [31:0] exp, input string name);
    txn_t t;
    bit   acked = 0;
    t.is_read = (strb == 4'h0);
    t.exp     = exp;
    t.name    = name;
    @(negedge clk);
    sbq.push_back(t);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + {28'h0, idx, 2'b00};
    iomem_wstrb = strb;
    iomem_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) begin
        acked = 1;
        break;
      end
    end
    if (!acked) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout_%s: no ack within 20 cycles, required ack", name);
      void'(sbq.pop_back());
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp, input string name);
    bus(idx, 4'h0, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] strb, input logic [31:0] wd);
    bus(idx, strb, wd, 32'h0, "write");
  endtask

  task automatic read_data(input string name);
    rd(2'd2, m_data(), name);
    m_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string name);
    for (int i = 0; i < 2000 && irq_count < n; i++) @(negedge clk);
    check(name, irq_count, n);
    repeat (2 * C) @(negedge clk);
  endtask

  task automatic single_frame(input logic [15:0] w, input string name);
    sensor_word = w;
    frame_exp++;
    wr(2'd0, 4'h1, {30'b0, 1'b1, m_en});
    wait_frames(frame_exp, name);
    m_frame(w);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v, mw;
    logic [3:0]  s;
    logic [15:0] w;
    bit          ack_seen;
    int          nf;

    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_addr  = '0;
    iomem_wstrb = '0;
    iomem_wdata = '0;
    so          = 1'b0;
    frame_exp   = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset_cs_n", {31'b0, cs_n}, 32'h1);
    check("reset_sck", {31'b0, sck}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_ready", {31'b0, iomem_ready}, 32'h0);
    check("reset_rdata", iomem_rdata, 32'h0);
    reset = 1'b0;

    rd(2'd0, 32'h0, "ctrl_reset");
    rd(2'd1, 32'd1024, "period_reset");
    read_data("data_reset");
    rd(2'd3, 32'h0, "raw_reset");

    // PERIOD byte strobes and clamping
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 32'h0000_0010 : $urandom;
      s = (i == 0) ? 4'hF : 4'($urandom_range(1, 15));
      mw = {8'h00, m_period};
      for (int b = 0; b < 4; b++) if (s[b]) mw[8*b +: 8] = v[8*b +: 8];
      m_period = (mw[23:0] < 24'd1024) ? 24'd1024 : mw[23:0];
      wr(2'd1, s, v);
      rd(2'd1, {8'h00, m_period}, "period_strobe");
    end
    wr(2'd1, 4'hF, 32'd5);
    m_period = 24'd1024;
    rd(2'd1, 32'd1024, "period_clamp");

    // single shot, 100.00 C
    single_frame(16'h0C80, "frame_0c80");
    check("cs_low_cycles", last_low, 33 * C);
    check("sck_rises", last_rises, 16);
    rd(2'd2, 32'h0001_2190, "data_0c80");
    m_valid = 1'b0;
    rd(2'd3, 32'h0000_0C80, "raw_0c80");

    // open thermocouple, VALID cleared by read
    single_frame(16'h0004, "frame_open");
    rd(2'd2, 32'h0002_3000, "data_open");
    rd(2'd2, 32'h0002_1000, "data_valid_clr");
    m_valid = 1'b0;

    // random frames, some left unread so VALID persists
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      single_frame(w, "frame_rand");
      if (i % 2 == 1) read_data("data_rand");
      rd(2'd3, {16'h0, m_raw}, "raw_rand");
    end
    read_data("data_rand_final");

    // START during SHIFT is dropped
    sensor_word = 16'hA5A5;
    frame_exp++;
    wr(2'd0, 4'h1, 32'h2);
    repeat (30) @(negedge clk);
    wr(2'd0, 4'h1, 32'h2);
    wait_frames(frame_exp, "frame_start_in_shift");
    repeat (200) @(negedge clk);
    check("start_in_shift_one_frame", irq_count, frame_exp);
    m_frame(16'hA5A5);
    rd(2'd0, 32'h0, "ctrl_start_reads_0");
    read_data("data_a5a5");

    // DATA read in the same cycle as frame completion
    w = 16'($urandom);
    sensor_word = w;
    frame_exp++;
    wr(2'd0, 4'h1, 32'h2);
    repeat (33 * C - 2) @(negedge clk);
    rd(2'd2, m_data(), "data_same_cycle_old");
    m_frame(w);
    wait_frames(frame_exp, "frame_same_cycle");
    read_data("data_same_cycle_valid");
    read_data("data_same_cycle_clr");

    // read-only registers ignore writes but ack them
    wr(2'd2, 4'hF, 32'hFFFF_FFFF);
    wr(2'd3, 4'hF, 32'hFFFF_FFFF);
    read_data("data_ro");
    rd(2'd3, {16'h0, m_raw}, "raw_ro");

    // undecoded address is never acked
    ack_seen = 0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0008;
    iomem_wstrb = 4'h0;
    repeat (8) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) ack_seen = 1;
    end
    iomem_valid = 1'b0;
    check("undecoded_no_ack", {31'b0, ack_seen}, 32'h0);

    // periodic mode, PERIOD clamped to 1024
    fall_cyc.delete();
    sensor_word = 16'h1234;
    m_en = 1'b1;
    wr(2'd0, 4'h1, 32'h1);
    for (int i = 0; i < 6000 && fall_cyc.size() < 4; i++) @(negedge clk);
    check("periodic_frames_seen", fall_cyc.size() >= 4, 32'h1);
    if (fall_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) check("period_spacing", fall_cyc[i] - fall_cyc[i-1], 1024);
    m_en = 1'b0;
    wr(2'd0, 4'h1, 32'h0);
    repeat (300) @(negedge clk);
    nf = fall_cyc.size();
    frame_exp += nf;
    for (int i = 0; i < nf; i++) m_frame(16'h1234);
    check("periodic_irq_count", irq_count, frame_exp);
    read_data("data_periodic");

    // sample counter wrap
    @(negedge clk);
    force dut.sample_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt;
    m_cnt = 16'hFFFF;
    single_frame(16'($urandom), "frame_wrap");
    check("cnt_wrap_model", {16'h0, m_cnt}, 32'h0);
    read_data("data_cnt_wrap");

    // reset in the middle of SHIFT
    sensor_word = 16'hFFFF;
    wr(2'd0, 4'h1, 32'h2);
    repeat (20) @(negedge clk);
    check("cs_low_before_reset", {31'b0, cs_n}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", {31'b0, cs_n}, 32'h1);
    check("abort_sck", {31'b0, sck}, 32'h0);
    check("abort_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    m_reset();
    read_data("data_after_abort");
    rd(2'd1, 32'd1024, "period_after_abort");
    repeat (200) @(negedge clk);

    check("irq_total", irq_count, frame_exp);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
